// File: rtl/main_decoder_pipe.sv
// Registered main decoder for the Decode stage: opcode -> control bundle,
// delivered through a two-entry skid buffer with flush and an illegal-opcode counter.
module main_decoder_pipe #(
  parameter int IMM_W    = 3,
  parameter bit EN_UPPER = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             ALUSrcA,
  output logic             MemWrite,
  output logic             Branch,
  output logic             Jump,
  output logic             Jalr,
  output logic             Illegal,
  output logic [1:0]       ResultSrc,
  output logic [IMM_W-1:0] ImmSrc,
  output logic [1:0]       ALUOp,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clr
);

  typedef struct packed {
    logic             reg_write;
    logic             alu_src;
    logic             alu_src_a;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             jalr;
    logic             illegal;
    logic [1:0]       result_src;
    logic [IMM_W-1:0] imm_src;
    logic [1:0]       alu_op;
  } ctrl_t;

  ctrl_t            dec_d;
  logic [2:0]       imm3;
  ctrl_t            main_q, skid_q;
  logic             main_v_q, skid_v_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // J and U immediates need the 3-bit ImmSrc encoding; narrower builds treat them as illegal.
  always_comb begin
    dec_d = '0;
    imm3  = 3'b000;
    case (Op)
      7'b0000011: begin dec_d.reg_write = 1'b1; imm3 = 3'b001; dec_d.alu_src = 1'b1; dec_d.result_src = 2'b01; end
      7'b0100011: begin imm3 = 3'b011; dec_d.alu_src = 1'b1; dec_d.mem_write = 1'b1; end
      7'b0110011: begin dec_d.reg_write = 1'b1; dec_d.alu_op = 2'b10; end
      7'b0010011: begin dec_d.reg_write = 1'b1; imm3 = 3'b001; dec_d.alu_src = 1'b1; dec_d.alu_op = 2'b11; end
      7'b1100011: begin imm3 = 3'b010; dec_d.branch = 1'b1; dec_d.alu_op = 2'b01; end
      7'b1101111: begin
        if (IMM_W >= 3) begin
          dec_d.reg_write = 1'b1; imm3 = 3'b100; dec_d.jump = 1'b1; dec_d.result_src = 2'b10;
        end else dec_d.illegal = 1'b1;
      end
      7'b1100111: begin
        dec_d.reg_write = 1'b1; imm3 = 3'b001; dec_d.alu_src = 1'b1;
        dec_d.jump = 1'b1; dec_d.jalr = 1'b1; dec_d.result_src = 2'b10;
      end
      7'b0110111: begin
        if (EN_UPPER && IMM_W >= 3) begin
          dec_d.reg_write = 1'b1; imm3 = 3'b101; dec_d.result_src = 2'b11;
        end else dec_d.illegal = 1'b1;
      end
      7'b0010111: begin
        if (EN_UPPER && IMM_W >= 3) begin
          dec_d.reg_write = 1'b1; imm3 = 3'b101; dec_d.alu_src = 1'b1; dec_d.alu_src_a = 1'b1;
        end else dec_d.illegal = 1'b1;
      end
      default: dec_d.illegal = 1'b1;
    endcase
    dec_d.imm_src = imm3[IMM_W-1:0];
  end

  // Handshake: a transfer occurs on a rising edge where valid and ready are both high;
  // valid never depends on ready, and in_ready is simply "skid entry empty".
  assign in_ready = ~skid_v_q;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (flush) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (!main_v_q || out_ready) begin
      if (skid_v_q) begin
        main_q   <= skid_q;
        main_v_q <= 1'b1;
        skid_v_q <= 1'b0;
      end else if (accept) begin
        main_q   <= dec_d;
        main_v_q <= 1'b1;
      end else begin
        main_v_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= dec_d;
      skid_v_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (accept && !flush && dec_d.illegal && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid   = main_v_q;
  assign RegWrite    = main_q.reg_write;
  assign ALUSrc      = main_q.alu_src;
  assign ALUSrcA     = main_q.alu_src_a;
  assign MemWrite    = main_q.mem_write;
  assign Branch      = main_q.branch;
  assign Jump        = main_q.jump;
  assign Jalr        = main_q.jalr;
  assign Illegal     = main_q.illegal;
  assign ResultSrc   = main_q.result_src;
  assign ImmSrc      = main_q.imm_src;
  assign ALUOp       = main_q.alu_op;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_main_decoder_pipe.sv
// Bench for main_decoder_pipe: a default instance and a narrow one (IMM_W=2, no upper
// opcodes, 2-bit counter) share stimulus and are checked against a FIFO-level model.
module tb_main_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       in_valid, flush, out_ready, cnt_clr;

  always #5 clk = ~clk;

  logic       a_in_ready, a_out_valid, a_rw, a_as, a_asa, a_mw, a_br, a_j, a_jr, a_ill;
  logic [1:0] a_res, a_aop;
  logic [2:0] a_imm;
  logic [7:0] a_cnt;
  logic       b_in_ready, b_out_valid, b_rw, b_as, b_asa, b_mw, b_br, b_j, b_jr, b_ill;
  logic [1:0] b_res, b_aop;
  logic [1:0] b_imm;
  logic [1:0] b_cnt;
  logic [14:0] a_bun, b_bun;

  assign a_bun = {a_rw, a_as, a_asa, a_mw, a_br, a_j, a_jr, a_ill, a_res, a_imm, a_aop};
  assign b_bun = {b_rw, b_as, b_asa, b_mw, b_br, b_j, b_jr, b_ill, b_res, 1'b0, b_imm, b_aop};

  main_decoder_pipe dut_a (
    .clk(clk), .rst(rst_n), .Op(op), .in_valid(in_valid), .in_ready(a_in_ready),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .RegWrite(a_rw), .ALUSrc(a_as), .ALUSrcA(a_asa), .MemWrite(a_mw), .Branch(a_br),
    .Jump(a_j), .Jalr(a_jr), .Illegal(a_ill), .ResultSrc(a_res), .ImmSrc(a_imm),
    .ALUOp(a_aop), .illegal_cnt(a_cnt), .cnt_clr(cnt_clr)
  );

  main_decoder_pipe #(.IMM_W(2), .EN_UPPER(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_n), .Op(op), .in_valid(in_valid), .in_ready(b_in_ready),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .RegWrite(b_rw), .ALUSrc(b_as), .ALUSrcA(b_asa), .MemWrite(b_mw), .Branch(b_br),
    .Jump(b_j), .Jalr(b_jr), .Illegal(b_ill), .ResultSrc(b_res), .ImmSrc(b_imm),
    .ALUOp(b_aop), .illegal_cnt(b_cnt), .cnt_clr(cnt_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Bundle layout: {RegWrite,ALUSrc,ALUSrcA,MemWrite,Branch,Jump,Jalr,Illegal,ResultSrc,ImmSrc[2:0],ALUOp}
  function automatic logic [14:0] exp_bundle(input logic [6:0] o, input int k);
    bit         wide = (k == 0);
    logic       rw = 0, as = 0, asa = 0, mw = 0, br = 0, j = 0, jr = 0, ill = 0;
    logic [1:0] res = 0, aop = 0;
    logic [2:0] imm = 0;
    case (o)
      7'b0000011: begin rw = 1; imm = 1; as = 1; res = 1; end
      7'b0100011: begin imm = 3; as = 1; mw = 1; end
      7'b0110011: begin rw = 1; aop = 2; end
      7'b0010011: begin rw = 1; imm = 1; as = 1; aop = 3; end
      7'b1100011: begin imm = 2; br = 1; aop = 1; end
      7'b1101111: if (wide) begin rw = 1; imm = 4; j = 1; res = 2; end else ill = 1;
      7'b1100111: begin rw = 1; imm = 1; as = 1; j = 1; jr = 1; res = 2; end
      7'b0110111: if (wide) begin rw = 1; imm = 5; res = 3; end else ill = 1;
      7'b0010111: if (wide) begin rw = 1; imm = 5; as = 1; asa = 1; end else ill = 1;
      default: ill = 1;
    endcase
    return {rw, as, asa, mw, br, j, jr, ill, res, imm, aop};
  endfunction

  // Model: each instance is a 2-deep FIFO of bundles; outputs show the head, or the
  // last shown head when empty.
  logic [14:0] slot [2][2];
  int          n [2];
  logic [14:0] shown [2];
  int          cnt [2];
  int          cmax [2] = '{255, 3};

  always @(posedge clk or negedge rst_n) begin
    bit          acc, del;
    logic [14:0] v;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        n[k] = 0; shown[k] = '0; cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        acc = in_valid && (n[k] < 2);
        del = (n[k] > 0) && out_ready;
        v   = exp_bundle(op, k);
        if (cnt_clr) cnt[k] = 0;
        else if (acc && !flush && v[7] && cnt[k] < cmax[k]) cnt[k] = cnt[k] + 1;
        if (flush) n[k] = 0;
        else begin
          if (del) begin slot[k][0] = slot[k][1]; n[k] = n[k] - 1; end
          if (acc) begin slot[k][n[k]] = v; n[k] = n[k] + 1; end
        end
        if (n[k] > 0) shown[k] = slot[k][0];
      end
    end
  end

  always @(negedge clk) begin
    check("a_out_valid", a_out_valid, n[0] > 0);
    check("a_in_ready", a_in_ready, n[0] < 2);
    check("a_bundle", a_bun, shown[0]);
    check("a_cnt", a_cnt, cnt[0]);
    check("b_out_valid", b_out_valid, n[1] > 0);
    check("b_in_ready", b_in_ready, n[1] < 2);
    check("b_bundle", b_bun, shown[1]);
    check("b_cnt", b_cnt, cnt[1]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    rst_n = 1'b0; op = '0; in_valid = 0; flush = 0; out_ready = 0; cnt_clr = 0;
    #2;
    check("rst_valid", a_out_valid, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_cnt", a_cnt, 0);
    check("rst_bundle", a_bun, 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // back-to-back with out_ready high
    out_ready = 1; in_valid = 1; op = 7'b0000011; step();
    check("t1_load_valid", a_out_valid, 1); check("t1_load_res", a_res, 2'b01);
    check("t1_load_imm", a_imm, 3'b001); check("t1_load_mw", a_mw, 0);
    op = 7'b0100011; step();
    check("t1_st_valid", a_out_valid, 1); check("t1_st_res", a_res, 2'b00);
    check("t1_st_imm", a_imm, 3'b011); check("t1_st_mw", a_mw, 1);
    op = 7'b0110011; step();
    check("t1_r_valid", a_out_valid, 1); check("t1_r_imm", a_imm, 3'b000);
    check("t1_r_aop", a_aop, 2'b10);
    op = 7'b1101111; step();
    check("t1_jal_valid", a_out_valid, 1); check("t1_jal_res", a_res, 2'b10);
    check("t1_jal_imm", a_imm, 3'b100); check("t1_jal_narrow_ill", b_ill, 1);
    in_valid = 0; step();
    check("t1_drain", a_out_valid, 0);

    // backpressure into the skid entry
    out_ready = 0; in_valid = 1; op = 7'b0010011; step();
    check("t2_ready1", a_in_ready, 1);
    op = 7'b1100011; step();
    check("t2_ready0", a_in_ready, 0); check("t2_hold_aop", a_aop, 2'b11);
    in_valid = 0; step();
    check("t2_still_i", a_aop, 2'b11);
    out_ready = 1; step();
    check("t2_br", a_br, 1); check("t2_br_aop", a_aop, 2'b01); check("t2_ready_back", a_in_ready, 1);
    step();
    check("t2_empty", a_out_valid, 0);

    // flush with two entries held and a concurrent LUI
    out_ready = 0; in_valid = 1; op = 7'b0110011; step();
    op = 7'b0000011; step();
    flush = 1; op = 7'b0110111; step();
    check("t3_valid", a_out_valid, 0); check("t3_ready", a_in_ready, 1);
    flush = 0; in_valid = 0; out_ready = 1; step();
    check("t3_no_lui", a_out_valid, 0);
    cnt_clr = 1; step(); cnt_clr = 0;
    check("t3_clr", a_cnt, 0);
    out_ready = 0; in_valid = 1; op = 7'b0110011; step();
    flush = 1; op = 7'b0110111; step();
    check("t3_flush_not_counted", b_cnt, 0); check("t3_b_valid", b_out_valid, 0);
    flush = 0; in_valid = 0;

    // illegal opcodes and the saturating counter
    out_ready = 1; in_valid = 1; op = 7'b1111111;
    repeat (3) begin
      step();
      check("t4_ill", a_ill, 1); check("t4_rw", a_rw, 0);
    end
    check("t4_cnt3", a_cnt, 3); check("t4_b_cnt3", b_cnt, 3);
    cnt_clr = 1; step(); cnt_clr = 0;
    check("t4_clr_prio", a_cnt, 0); check("t4_b_clr_prio", b_cnt, 0);
    repeat (5) step();
    check("t4_cnt5", a_cnt, 5); check("t4_b_sat", b_cnt, 3);

    // parameter-dependent decodes
    op = 7'b0010111; step();
    check("t5_auipc_ill", a_ill, 0); check("t5_auipc_srca", a_asa, 1);
    check("t5_auipc_imm", a_imm, 3'b101); check("t5_auipc_narrow", b_ill, 1);
    op = 7'b1100111; step();
    check("t5_jalr_j", a_j, 1); check("t5_jalr_jr", a_jr, 1);
    check("t5_jalr_imm", a_imm, 3'b001); check("t5_jalr_narrow_imm", b_imm, 2'b01);
    op = 7'b1101111; step();
    check("t5_jal_narrow", b_ill, 1);

    // async reset mid-stream
    out_ready = 0; op = 7'b1111111; step(); step();
    in_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    check("t6_valid", a_out_valid, 0); check("t6_ready", a_in_ready, 1);
    check("t6_cnt", a_cnt, 0); check("t6_bundle", a_bun, 0); check("t6_b_cnt", b_cnt, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // randomized traffic
    repeat (3000) begin
      @(negedge clk);
      #1;
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 19) == 0;
      cnt_clr   = $urandom_range(0, 49) == 0;
      if ($urandom_range(0, 3) == 0) op = 7'($urandom_range(0, 127));
      else op = ops[$urandom_range(0, 8)];
    end
    in_valid = 0; flush = 0; cnt_clr = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
